// File: rtl/hermes_pkg.sv
// Shared types and defaults for the Hermes virtual-channel input buffer.
package hermes_pkg;

  localparam int unsigned DEF_FLIT_WIDTH = 16;
  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_NUM_VC     = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_SENDHDR = 3'd2,
    ST_SIZE    = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_END     = 3'd5
  } lane_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hermes_vc_buffer_if.sv
// Router-side bus of the VC input buffer. HERMES_VCBUF_ERRCHK_EN adds err_o.
interface hermes_vc_buffer_if import hermes_pkg::*; #(
  parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int unsigned NUM_VC     = DEF_NUM_VC,
  parameter int unsigned SEL_WIDTH  = (NUM_VC > 1) ? clog2(NUM_VC) : 1
);

  logic                         rx;
  logic [SEL_WIDTH-1:0]         lane_sel;
  logic [FLIT_WIDTH-1:0]        data_in;
  logic [NUM_VC-1:0]            credit_o;
  logic [NUM_VC-1:0]            h;
  logic [NUM_VC-1:0]            ack_h;
  logic [NUM_VC-1:0]            data_av;
  logic [NUM_VC*FLIT_WIDTH-1:0] data;
  logic [NUM_VC-1:0]            data_ack;
  logic [NUM_VC-1:0]            sender;
`ifdef HERMES_VCBUF_ERRCHK_EN
  logic [NUM_VC-1:0]            err_o;

  modport master (
    output rx, lane_sel, data_in, ack_h, data_ack,
    input  credit_o, h, data_av, data, sender, err_o
  );

  modport slave (
    input  rx, lane_sel, data_in, ack_h, data_ack,
    output credit_o, h, data_av, data, sender, err_o
  );
`else
  modport master (
    output rx, lane_sel, data_in, ack_h, data_ack,
    input  credit_o, h, data_av, data, sender
  );

  modport slave (
    input  rx, lane_sel, data_in, ack_h, data_ack,
    output credit_o, h, data_av, data, sender
  );
`endif

endinterface

// File: rtl/hermes_vc_lane.sv
// One virtual-channel lane: DEPTH-entry flit FIFO plus packet-tracking FSM.
// HERMES_VCBUF_ERRCHK_EN adds the sticky err output.
module hermes_vc_lane import hermes_pkg::*; #(
  parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                  clock_rx,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [FLIT_WIDTH-1:0] din,
  output logic                  credit,
  output logic                  h,
  input  logic                  ack_h,
  output logic                  data_av,
  output logic [FLIT_WIDTH-1:0] dout,
  input  logic                  data_ack,
  output logic                  sender
`ifdef HERMES_VCBUF_ERRCHK_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [FLIT_WIDTH-1:0] flit_cnt;
  lane_state_e           state;
  logic                  empty;
  logic                  wr_acc;
  logic                  pop;

  assign empty   = (count == '0);
  assign credit  = (count != CW'(DEPTH));
  assign wr_acc  = wr_req && credit;
  assign data_av = !empty &&
                   ((state == ST_SENDHDR) || (state == ST_SIZE) || (state == ST_PAYLOAD));
  assign pop     = data_ack && data_av;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; pointers define validity.
  always_ff @(posedge clock_rx) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock_rx or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet FSM: request route for head flit, then track header/size/payload pops.
  always_ff @(posedge clock_rx or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      h        <= 1'b0;
      sender   <= 1'b0;
      flit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            h     <= 1'b1;
            state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (ack_h) begin
            h      <= 1'b0;
            sender <= 1'b1;
            state  <= ST_SENDHDR;
          end
        end
        ST_SENDHDR: begin
          if (pop) state <= ST_SIZE;
        end
        ST_SIZE: begin
          if (pop) begin
            flit_cnt <= dout;
            if (dout == '0) begin
              sender <= 1'b0;
              state  <= ST_END;
            end else begin
              state  <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (pop) begin
            flit_cnt <= flit_cnt - FLIT_WIDTH'(1);
            if (flit_cnt == FLIT_WIDTH'(1)) begin
              sender <= 1'b0;
              state  <= ST_END;
            end
          end
        end
        ST_END: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HERMES_VCBUF_ERRCHK_EN
  localparam int unsigned SIZE_LIMIT = DEPTH * 64;

  // Sticky: overflow attempt or implausible packet size.
  always_ff @(posedge clock_rx or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((wr_req && !credit) ||
                 (pop && (state == ST_SIZE) && (32'(dout) > SIZE_LIMIT))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/hermes_vc_buffer.sv
// Hermes multi-lane VC input buffer: write demux into NUM_VC independent lanes.
// HERMES_VCBUF_ERRCHK_EN enables the per-lane sticky err_o output.
module hermes_vc_buffer import hermes_pkg::*; #(
  parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned NUM_VC     = DEF_NUM_VC
) (
  input  logic              clock_rx,
  input  logic              reset,
  hermes_vc_buffer_if.slave bus
);

  localparam int unsigned SEL_WIDTH = (NUM_VC > 1) ? clog2(NUM_VC) : 1;

  logic [NUM_VC-1:0]            credit;
  logic [NUM_VC-1:0]            hreq;
  logic [NUM_VC-1:0]            avail;
  logic [NUM_VC-1:0]            sending;
  logic [NUM_VC*FLIT_WIDTH-1:0] head;
`ifdef HERMES_VCBUF_ERRCHK_EN
  logic [NUM_VC-1:0]            err;
  assign bus.err_o = err;
`endif

  assign bus.credit_o = credit;
  assign bus.h        = hreq;
  assign bus.data_av  = avail;
  assign bus.sender   = sending;
  assign bus.data     = head;

  // An out-of-range lane_sel matches no lane, so the write is dropped.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_lane
    logic wr_req;
    assign wr_req = bus.rx && (bus.lane_sel == SEL_WIDTH'(i));

    hermes_vc_lane #(
      .FLIT_WIDTH(FLIT_WIDTH),
      .DEPTH     (DEPTH)
    ) u_lane (
      .clock_rx (clock_rx),
      .reset    (reset),
      .wr_req   (wr_req),
      .din      (bus.data_in),
      .credit   (credit[i]),
      .h        (hreq[i]),
      .ack_h    (bus.ack_h[i]),
      .data_av  (avail[i]),
      .dout     (head[i*FLIT_WIDTH +: FLIT_WIDTH]),
      .data_ack (bus.data_ack[i]),
      .sender   (sending[i])
`ifdef HERMES_VCBUF_ERRCHK_EN
      ,
      .err      (err[i])
`endif
    );
  end

endmodule

// File: tb/tb_hermes_vc_buffer.sv
// Directed scoreboard bench for hermes_vc_buffer (default 16-bit, 16-deep, 2 lanes).
module tb_hermes_vc_buffer;
  import hermes_pkg::*;

  localparam int unsigned FW     = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NUM_VC = 2;

  logic clock_rx;
  logic reset;

  hermes_vc_buffer_if #(.FLIT_WIDTH(FW), .NUM_VC(NUM_VC)) bus ();

  hermes_vc_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clock_rx (clock_rx),
    .reset    (reset),
    .bus      (bus)
  );

  initial clock_rx = 1'b0;
  always #5 clock_rx = ~clock_rx;

  int          checks;
  int          passed;
  int          failed;
  int unsigned mcnt [NUM_VC];
  logic [FW-1:0] q0 [$];
  logic [FW-1:0] q1 [$];
  logic [FW-1:0] pa [4];
  logic [FW-1:0] pb [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check credit, score pops, record accepted writes, advance to next negedge.
  task automatic tick();
    logic [NUM_VC-1:0] pops;
    logic [NUM_VC-1:0] exp_credit;
    logic [FW-1:0]     e;
    logic              acc;
    int                l;
    for (int i = 0; i < int'(NUM_VC); i++) exp_credit[i] = (mcnt[i] != DEPTH);
    check("credit", 32'(bus.credit_o), 32'(exp_credit));
    l   = int'(bus.lane_sel);
    acc = bus.rx && (l < int'(NUM_VC)) && (mcnt[l] != DEPTH);
    pops = bus.data_ack & bus.data_av;
    for (int i = 0; i < int'(NUM_VC); i++) begin
      if (pops[i]) begin
        if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          check($sformatf("pop_empty_l%0d", i), 32'(pops[i]), 32'd0);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check($sformatf("data_l%0d", i), 32'(bus.data[i*FW +: FW]), 32'(e));
          mcnt[i]--;
        end
      end
    end
    if (acc) begin
      if (l == 0) q0.push_back(bus.data_in);
      else        q1.push_back(bus.data_in);
      mcnt[l]++;
    end
    @(posedge clock_rx);
    @(negedge clock_rx);
  endtask

  task automatic wr(input int lane, input logic [FW-1:0] d);
    bus.rx       = 1'b1;
    bus.lane_sel = 1'(lane);
    bus.data_in  = d;
    tick();
    bus.rx       = 1'b0;
  endtask

  task automatic wait_h(input logic [NUM_VC-1:0] m);
    int n;
    n = 0;
    while (((bus.h & m) != m) && (n < 20)) begin
      tick();
      n++;
    end
    check("wait_h", 32'(bus.h & m), 32'(m));
  endtask

  task automatic grant(input logic [NUM_VC-1:0] m);
    bus.ack_h = m;
    tick();
    bus.ack_h = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((q0.size() + q1.size()) > 0) && (n < 300)) begin
      tick();
      n++;
    end
    check("drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_credit"}, 32'(bus.credit_o), 32'h3);
    check({tag, "_h"},      32'(bus.h),        32'h0);
    check({tag, "_sender"}, 32'(bus.sender),   32'h0);
    check({tag, "_av"},     32'(bus.data_av),  32'h0);
`ifdef HERMES_VCBUF_ERRCHK_EN
    check({tag, "_err"},    32'(bus.err_o),    32'h0);
`endif
  endtask

  initial begin
    int n;
    checks = 0;
    passed = 0;
    failed = 0;
    for (int i = 0; i < int'(NUM_VC); i++) mcnt[i] = 0;
    pa = '{16'h0A00, 16'h0002, 16'h0A01, 16'h0A02};
    pb = '{16'h0B00, 16'h0003, 16'h0B01, 16'h0B02, 16'h0B03};
    reset        = 1'b1;
    bus.rx       = 1'b0;
    bus.lane_sel = '0;
    bus.data_in  = '0;
    bus.ack_h    = '0;
    bus.data_ack = '0;
    @(negedge clock_rx);
    @(negedge clock_rx);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clock_rx);

    // Basic packet on lane 0 with data_ack held throughout
    bus.data_ack = 2'b01;
    wr(0, 16'h0011);
    check("t1_h_before", 32'(bus.h[0]), 32'd0);
    wr(0, 16'h0002);
    check("t1_h_rise", 32'(bus.h[0]), 32'd1);
    wr(0, 16'hAAAA);
    wr(0, 16'hBBBB);
    check("t1_h_hold", 32'(bus.h[0]), 32'd1);
    check("t1_no_av", 32'(bus.data_av[0]), 32'd0);
    grant(2'b01);
    check("t1_h_drop", 32'(bus.h[0]), 32'd0);
    check("t1_sender_up", 32'(bus.sender[0]), 32'd1);
    n = 0;
    while ((q0.size() > 0) && (n < 20)) begin
      check("t1_sender_busy", 32'(bus.sender[0]), 32'd1);
      tick();
      n++;
    end
    check("t1_drain", 32'(q0.size()), 32'd0);
    check("t1_sender_fall", 32'(bus.sender[0]), 32'd0);
    tick();
    tick();
    check("t1_idle_h", 32'(bus.h[0]), 32'd0);
    check("t1_idle_av", 32'(bus.data_av[0]), 32'd0);
    bus.data_ack = '0;

    // Fill lane 1 to capacity; 17th write must be dropped
    wr(1, 16'h0100);
    wr(1, 16'd14);
    for (int k = 0; k < 14; k++) wr(1, 16'h1100 + 16'(k));
    check("t2_full", 32'(bus.credit_o[1]), 32'd0);
    check("t2_other", 32'(bus.credit_o[0]), 32'd1);
    wr(1, 16'hDEAD);
    check("t2_still_full", 32'(bus.credit_o[1]), 32'd0);
`ifdef HERMES_VCBUF_ERRCHK_EN
    check("t2_err", 32'(bus.err_o), 32'h2);
`endif
    wait_h(2'b10);
    grant(2'b10);
    bus.data_ack = 2'b10;
    drain();
    check("t2_sender", 32'(bus.sender[1]), 32'd0);
    tick();
    tick();
    tick();
    check("t2_no_extra", 32'(bus.h[1]), 32'd0);
    bus.data_ack = '0;

    // Zero-size packet followed by another zero-size packet
    wr(0, 16'h0022);
    wr(0, 16'h0000);
    wr(0, 16'h0033);
    wr(0, 16'h0000);
    wait_h(2'b01);
    grant(2'b01);
    bus.data_ack = 2'b01;
    tick();
    tick();
    check("t3_sender", 32'(bus.sender[0]), 32'd0);
    check("t3_end_av", 32'(bus.data_av[0]), 32'd0);
    check("t3_left", 32'(q0.size()), 32'd2);
    tick();
    check("t3_idle_h", 32'(bus.h[0]), 32'd0);
    tick();
    check("t3_next_h", 32'(bus.h[0]), 32'd1);
    grant(2'b01);
    drain();
    check("t3_sender2", 32'(bus.sender[0]), 32'd0);
    bus.data_ack = '0;

    // Interleaved packets, both lanes popped together
    for (int k = 0; k < 5; k++) begin
      if (k < 4) wr(0, pa[k]);
      wr(1, pb[k]);
    end
    wait_h(2'b11);
    grant(2'b11);
    bus.data_ack = 2'b11;
    drain();
    tick();
    check("t4_sender", 32'(bus.sender), 32'h0);
    bus.data_ack = '0;

    // Streaming: write and pop lane 0 every cycle, 64-flit payload
    wr(0, 16'h0D00);
    wr(0, 16'h0040);
    for (int k = 0; k < 3; k++) wr(0, 16'hE000 + 16'(k));
    wait_h(2'b01);
    grant(2'b01);
    bus.data_ack = 2'b01;
    for (int k = 3; k < 64; k++) begin
      bus.rx       = 1'b1;
      bus.lane_sel = 1'b0;
      bus.data_in  = 16'hE000 + 16'(k);
      if (k < 43) check("t5_av", 32'(bus.data_av[0]), 32'd1);
      tick();
    end
    bus.rx = 1'b0;
    drain();
    check("t5_sender", 32'(bus.sender[0]), 32'd0);
    bus.data_ack = '0;

    // Reset in the middle of a payload on lane 1
    wr(1, 16'h0E00);
    wr(1, 16'h0005);
    wr(1, 16'h0E01);
    wr(1, 16'h0E02);
    wait_h(2'b10);
    grant(2'b10);
    bus.data_ack = 2'b10;
    tick();
    tick();
    tick();
    bus.data_ack = '0;
    check("t6_mid_sender", 32'(bus.sender[1]), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_state("t6_rst");
    q0.delete();
    q1.delete();
    for (int i = 0; i < int'(NUM_VC); i++) mcnt[i] = 0;
    @(negedge clock_rx);
    reset = 1'b0;
    tick();
    tick();
    check("t6_no_resume_h", 32'(bus.h), 32'h0);
    check("t6_no_resume_av", 32'(bus.data_av), 32'h0);
    wr(1, 16'h0C00);
    wr(1, 16'h0001);
    wr(1, 16'h0C01);
    wait_h(2'b10);
    grant(2'b10);
    bus.data_ack = 2'b10;
    drain();
    check("t6_sender", 32'(bus.sender[1]), 32'd0);
    bus.data_ack = '0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hermes_vc_buffer.md
HERMES_VC_BUFFER -- requirements
Module: hermes_vc_buffer

Interface
REQ-001 Parameter FLIT_WIDTH, default 16, flit width in bits (8..32).
REQ-002 Parameter DEPTH, default 16, flits per lane; SHALL be a power of two, 4..64.
REQ-003 Parameter NUM_VC, default 2, number of virtual-channel lanes (1..4).
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 clock_rx  input  1  clock_rx; sole clock, all logic on its rising edge.
REQ-006 rx  input  1  write strobe for data_in.
REQ-007 lane_sel  input  max(1,clog2(NUM_VC))  target lane of the write.
REQ-008 data_in  input  FLIT_WIDTH  incoming flit.
REQ-009 credit_o  output  NUM_VC  per-lane credit, 1 = lane not full.
REQ-010 h  output  NUM_VC  per-lane routing request, header at lane head.
REQ-011 ack_h  input  NUM_VC  per-lane routing grant.
REQ-012 data_av  output  NUM_VC  per-lane head flit valid.
REQ-013 data  output  NUM_VC*FLIT_WIDTH  per-lane head flit, lane i at bits [i*FLIT_WIDTH +: FLIT_WIDTH].
REQ-014 data_ack  input  NUM_VC  per-lane pop of head flit.
REQ-015 sender  output  NUM_VC  per-lane packet-in-transfer flag.

Function
REQ-016 Each lane SHALL be an independent DEPTH-entry FIFO with an occupancy count of clog2(DEPTH)+1 bits; all DEPTH entries usable.
REQ-017 credit_o[i] SHALL be combinational: 1 iff count[i] != DEPTH.
REQ-018 Write accepted iff rx=1 and credit_o[lane_sel]=1; accepted flit stored at the lane tail on that edge; rejected write dropped, no state change.
REQ-019 lane_sel >= NUM_VC SHALL be treated as a rejected write.
REQ-020 Pop on lane i iff data_ack[i]=1 and data_av[i]=1; data_ack without data_av ignored.
REQ-021 Simultaneous accepted write and pop on the same lane: count unchanged, both pointers advance, wrap-around from DEPTH-1 to 0.
REQ-022 Packet format: header flit, size flit S, then S payload flits.
REQ-023 Per-lane FSM states IDLE, HEADER, SENDHDR, SIZE, PAYLOAD, END.
REQ-024 IDLE: if lane non-empty, next edge h[i]=1 and go HEADER (one-cycle latency write-to-h minimum).
REQ-025 HEADER: hold h[i]=1 until ack_h[i]=1; on that edge h[i]=0, sender[i]=1, go SENDHDR.
REQ-026 SENDHDR: pop of header flit goes to SIZE.
REQ-027 SIZE: pop loads flit counter (FLIT_WIDTH bits) with head value S; S=0 goes to END, else PAYLOAD.
REQ-028 PAYLOAD: each pop decrements counter; pop with counter=1 clears sender[i], goes END.
REQ-029 END: one cycle, then IDLE; a following packet already buffered raises h on the next edge.
REQ-030 data_av[i] SHALL be combinational: 1 iff state in {SENDHDR, SIZE, PAYLOAD} and lane non-empty.
REQ-031 data[i] SHALL always present the lane head entry; undefined content when empty is permitted.
REQ-032 Lanes SHALL not interact; ack_h/data_ack on one lane never affect another.

Reset
REQ-033 On reset: all pointers, counts, counters zero; FSMs IDLE; h=0, sender=0, data_av=0, credit_o all 1.
REQ-034 Reset mid-packet SHALL discard all buffered flits; no partial packet resumes after release.

Configuration
REQ-035 Macro HERMES_VCBUF_ERRCHK_EN defined: adds output err_o (NUM_VC bits), sticky per lane, set on a write rejected for full lane or on a pop in SIZE with S > DEPTH*64; cleared only by reset.
REQ-036 Macro undefined: no err_o port, no error logic; behaviour otherwise identical.

Structure
REQ-037 Package hermes_pkg SHALL hold the lane state enum, default FLIT_WIDTH/DEPTH/NUM_VC constants and clog2 helper.
REQ-038 Sub-module hermes_vc_lane (one FIFO plus FSM) SHALL be instantiated NUM_VC times by generate; top holds write demux and port packing.

Verification
REQ-039 Lane 0 write header 0x0011, size 0x0002, payload 0xAAAA, 0xBBBB; ack_h after 3 cycles; data_ack held -> h rises 1 cycle after first write, data sequence 0x0011,0x0002,0xAAAA,0xBBBB, sender falls with last pop.
REQ-040 16 writes to lane 1, no pops -> credit_o[1]=0 after 16th; 17th write dropped (err_o[1]=1 with macro); credit_o[0] stays 1.
REQ-041 Size flit 0x0000 -> header and size popped, END then IDLE, sender cleared, no payload consumed.
REQ-042 Interleaved packets on lanes 0 and 1 with simultaneous data_ack -> each lane delivers its own flits in order, no cross-lane corruption.
REQ-043 Write and pop same lane each cycle for 40 cycles -> count constant, pointer wrap correct, data order preserved.
REQ-044 Reset asserted mid-PAYLOAD -> outputs per REQ-033 immediately; new packet after release delivered correctly.
